// File: rtl/calc_pkg.sv
// Shared types for calc_binar_gen: FSM states, ALU opcodes and the serial frame length.
// Frame length includes a trailing even-parity bit when CALC_PARITY_EN is defined.
package calc_pkg;

  localparam int unsigned SEL_W = 32'd4;

  typedef enum logic [2:0] {
    ST_KEY    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_CALC   = 3'd2,
    ST_STORE  = 3'd3,
    ST_TX     = 3'd4,
    ST_LOCKED = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_ROTL = 4'd8,
    OP_ROTR = 4'd9,
    OP_EQ   = 4'd10,
    OP_LT   = 4'd11,
    OP_MUL  = 4'd12,
    OP_MAX  = 4'd13,
    OP_MIN  = 4'd14,
    OP_INC  = 4'd15
  } op_e;

  function automatic int unsigned frame_len(input int unsigned width);
`ifdef CALC_PARITY_EN
    return SEL_W + 32'd3 * width + 32'd1;
`else
    return SEL_W + 32'd3 * width;
`endif
  endfunction

endpackage

// File: rtl/calc_tx_serializer.sv
// Programmable-rate serial transmitter: holds the divider, shifts a frame out MSB first,
// DataOut changes on ClkTx falling edges, busy drops in the last cycle of the frame.
module calc_tx_serializer
  import calc_pkg::*;
#(
  parameter int unsigned LEN   = 32'd28,
  parameter int unsigned DIV_W = 32'd4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_i,
  input  logic [DIV_W-1:0] din_i,
  input  logic             load_i,
  input  logic [LEN-1:0]   frame_i,
  output logic             busy_o,
  output logic             clk_tx_o,
  output logic             data_out_o,
  output logic             dout_valid_o
);

  localparam int unsigned BIT_W = (LEN > 32'd1) ? $clog2(LEN) : 32'd1;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [BIT_W-1:0] bit_q;
  logic [LEN-1:0]   shift_q;
  logic             clk_q;
  logic             valid_q;
  logic             last_s;

  // Final cycle: high phase of the last bit is about to end.
  assign last_s = valid_q && clk_q && (cnt_q == div_q) && (bit_q == '0);
  assign busy_o = valid_q && !last_s;

  assign clk_tx_o     = clk_q;
  assign data_out_o   = shift_q[LEN-1];
  assign dout_valid_o = valid_q;

  // Divider register, phase counter and frame shifter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      clk_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (cfg_i) begin
        div_q <= din_i;
      end
      if (load_i) begin
        valid_q <= 1'b1;
        clk_q   <= 1'b0;
        cnt_q   <= '0;
        bit_q   <= BIT_W'(LEN - 32'd1);
        shift_q <= frame_i;
      end else if (valid_q) begin
        if (cnt_q == div_q) begin
          cnt_q <= '0;
          clk_q <= ~clk_q;
          if (clk_q) begin
            if (bit_q == '0) begin
              valid_q <= 1'b0;
              shift_q <= '0;
            end else begin
              bit_q   <= bit_q - BIT_W'(1);
              shift_q <= {shift_q[LEN-2:0], 1'b0};
            end
          end
        end else begin
          cnt_q <= cnt_q + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/calc_binar_gen.sv
// Key-locked ALU with result memory and serial transmitter (mode 0: compute+send, mode 1: store/read).
// Optional feature macro: CALC_PARITY_EN appends an even-parity bit to every transmitted frame.
module calc_binar_gen
  import calc_pkg::*;
#(
  parameter int unsigned        WIDTH     = 32'd8,
  parameter int unsigned        ADDR_W    = 32'd2,
  parameter int unsigned        KEY_LEN   = 32'd5,
  parameter logic [KEY_LEN-2:0] KEY_CODE  = 4'b0101,
  parameter int unsigned        MAX_TRIES = 32'd3,
  parameter int unsigned        DIV_W     = 32'd4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              input_key_i,
  input  logic              valid_cmd_i,
  input  logic              rw_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DIV_W-1:0]  din_i,
  input  logic              config_div_i,
  output logic              dout_valid_o,
  output logic              data_out_o,
  output logic              clk_tx_o,
  output logic              calc_busy_o,
  output logic              calc_active_o,
  output logic              calc_mode_o,
  output logic              calc_locked_o
);

  localparam int unsigned FRAME_W = SEL_W + 32'd3 * WIDTH;
  localparam int unsigned TX_LEN  = frame_len(WIDTH);
  localparam int          DEPTH   = 2 ** ADDR_W;
  localparam int unsigned KCNT_W  = (KEY_LEN > 32'd1) ? $clog2(KEY_LEN) : 32'd1;
  localparam int unsigned FAIL_W  = $clog2(MAX_TRIES + 32'd1);
  localparam logic [KCNT_W-1:0] KCNT_LAST = KCNT_W'(KEY_LEN - 32'd1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_TRIES - 32'd1);

  function automatic logic [WIDTH-1:0] alu(input logic [SEL_W-1:0] sel,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] r;
    sh = WIDTH'(b % WIDTH);
    case (op_e'(sel))
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SHL:  r = a << sh;
      OP_SHR:  r = a >> sh;
      OP_ROTL: r = (a << sh) | (a >> (WIDTH'(WIDTH) - sh));
      OP_ROTR: r = (a >> sh) | (a << (WIDTH'(WIDTH) - sh));
      OP_EQ:   r = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_LT:   r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MUL:  r = a * b;
      OP_MAX:  r = (a > b) ? a : b;
      OP_MIN:  r = (a < b) ? a : b;
      OP_INC:  r = a + WIDTH'(1);
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef CALC_PARITY_EN
  function automatic logic even_par(input logic [FRAME_W-1:0] f);
    return ^f;
  endfunction
`endif

  state_e              state_q, state_d;
  logic [KEY_LEN-1:0]  key_q, key_d;
  logic [KCNT_W-1:0]   kcnt_q, kcnt_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic                mode_q, mode_d;
  logic                active_q, active_d;
  logic                locked_q, locked_d;
  logic                busy_q, busy_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [FRAME_W-1:0]  mem_q [DEPTH];
  logic [FRAME_W-1:0]  calc_s, frame_s;
  logic [TX_LEN-1:0]   tx_word_s;
  logic                cfg_s, load_s, wr_s, tx_busy_s;

  assign calc_s  = {sel_q, a_q, b_q, alu(sel_q, a_q, b_q)};
  assign frame_s = rd_q ? mem_q[addr_q] : calc_s;
`ifdef CALC_PARITY_EN
  assign tx_word_s = {frame_s, even_par(frame_s)};
`else
  assign tx_word_s = frame_s;
`endif

  // Next-state logic: key entry/lockout, command capture and sequencing.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    kcnt_d   = kcnt_q;
    fail_d   = fail_q;
    mode_d   = mode_q;
    active_d = active_q;
    locked_d = locked_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    cfg_s    = 1'b0;
    load_s   = 1'b0;
    wr_s     = 1'b0;
    case (state_q)
      ST_KEY: begin
        if (valid_cmd_i) begin
          key_d[kcnt_q] = input_key_i;
          if (kcnt_q == KCNT_LAST) begin
            kcnt_d = '0;
            if (key_d[KEY_LEN-2:0] == KEY_CODE) begin
              state_d  = ST_IDLE;
              active_d = 1'b1;
              mode_d   = key_d[KEY_LEN-1];
            end else if (fail_q == FAIL_LAST) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              fail_d   = fail_q + FAIL_W'(1);
            end else begin
              fail_d = fail_q + FAIL_W'(1);
            end
          end else begin
            kcnt_d = kcnt_q + KCNT_W'(1);
          end
        end else begin
          kcnt_d = kcnt_q;
        end
      end
      ST_IDLE: begin
        if (valid_cmd_i) begin
          if (config_div_i) begin
            cfg_s = 1'b1;
          end else begin
            state_d = ST_CALC;
            a_d     = a_i;
            b_d     = b_i;
            sel_d   = sel_i;
            addr_d  = addr_i;
            rd_d    = mode_q & ~rw_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (mode_q && !rd_q) begin
          state_d = ST_STORE;
        end else begin
          load_s  = 1'b1;
          state_d = ST_TX;
        end
      end
      ST_STORE: begin
        wr_s    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_TX: begin
        if (!tx_busy_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TX;
        end
      end
      ST_LOCKED: state_d = ST_LOCKED;
      default:   state_d = ST_KEY;
    endcase
    busy_d = (state_d == ST_CALC) || (state_d == ST_STORE) || (state_d == ST_TX);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_KEY;
      key_q    <= '0;
      kcnt_q   <= '0;
      fail_q   <= '0;
      mode_q   <= 1'b0;
      active_q <= 1'b0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      kcnt_q   <= kcnt_d;
      fail_q   <= fail_d;
      mode_q   <= mode_d;
      active_q <= active_d;
      locked_q <= locked_d;
      busy_q   <= busy_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
    end
  end

  // Result memory; unwritten entries read back as an all-zero frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_s) begin
      mem_q[addr_q] <= calc_s;
    end
  end

  calc_tx_serializer #(
    .LEN   (TX_LEN),
    .DIV_W (DIV_W)
  ) u_tx (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_i        (cfg_s),
    .din_i        (din_i),
    .load_i       (load_s),
    .frame_i      (tx_word_s),
    .busy_o       (tx_busy_s),
    .clk_tx_o     (clk_tx_o),
    .data_out_o   (data_out_o),
    .dout_valid_o (dout_valid_o)
  );

  assign calc_busy_o   = busy_q;
  assign calc_active_o = active_q;
  assign calc_mode_o   = mode_q;
  assign calc_locked_o = locked_q;

endmodule

// File: tb/tb_calc_binar_gen.sv
// Scoreboard bench for calc_binar_gen: stimulus pushes expected frames and busy lengths,
// a monitor deserialises the link on ClkTx rising edges and compares.
module tb_calc_binar_gen;

  localparam int W = 8;
`ifdef CALC_PARITY_EN
  localparam int FL = 4 + 3 * W + 1;
`else
  localparam int FL = 4 + 3 * W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0] sel = '0;
  logic key_bit = 1'b0, valid = 1'b0, rw = 1'b0, cfg = 1'b0;
  logic [1:0] addr = '0;
  logic [3:0] din = '0;
  logic dout_valid, data_out, clk_tx, busy, active, mode, locked;

  calc_binar_gen dut (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a), .b_i(b), .sel_i(sel),
    .input_key_i(key_bit), .valid_cmd_i(valid), .rw_i(rw), .addr_i(addr),
    .din_i(din), .config_div_i(cfg),
    .dout_valid_o(dout_valid), .data_out_o(data_out), .clk_tx_o(clk_tx),
    .calc_busy_o(busy), .calc_active_o(active), .calc_mode_o(mode),
    .calc_locked_o(locked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_frame_q[$];
  int exp_busy_q[$];
  int div_m = 0;
  int mode_m = 0;
  logic [63:0] mem_m [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: result from the operation table, frame by weighted sum.
  function automatic logic [63:0] ref_frame(int av, int bv, int s);
    int m = (1 << W) - 1;
    int sh = bv % W;
    int r;
    case (s)
      0: r = (av + bv) & m;
      1: r = (av - bv) & m;
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: r = (~av) & m;
      6: r = (av << sh) & m;
      7: r = av >> sh;
      8: r = ((av << sh) | (av >> (W - sh))) & m;
      9: r = ((av >> sh) | (av << (W - sh))) & m;
      10: r = (av == bv) ? 1 : 0;
      11: r = (av < bv) ? 1 : 0;
      12: r = (av * bv) & m;
      13: r = (av > bv) ? av : bv;
      14: r = (av < bv) ? av : bv;
      default: r = (av + 1) & m;
    endcase
    return (64'(s) << (3 * W)) | (64'(av) << (2 * W)) | (64'(bv) << W) | 64'(r);
  endfunction

  function automatic logic [63:0] with_par(logic [63:0] f);
`ifdef CALC_PARITY_EN
    return (f << 1) | 64'($countones(f) & 1);
`else
    return f;
`endif
  endfunction

  function automatic int tx_busy_len();
    return FL * 2 * (div_m + 1) + 1;
  endfunction

  // Monitor: deserialise frames and measure busy windows.
  initial begin
    logic prev_clk, prev_valid;
    logic [63:0] acc;
    int nbits, bcnt;
    prev_clk = 1'b0; prev_valid = 1'b0; acc = '0; nbits = 0; bcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_clk = 1'b0; prev_valid = 1'b0; acc = '0; nbits = 0; bcnt = 0;
      end else begin
        if (dout_valid && clk_tx && !prev_clk) begin
          acc = {acc[62:0], data_out};
          nbits++;
        end
        if (prev_valid && !dout_valid) begin
          if (exp_frame_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_frame: got %0h expected none", acc);
          end else begin
            check("frame", acc, exp_frame_q.pop_front());
            check("frame_bits", 64'(nbits), 64'(FL));
          end
          acc = '0; nbits = 0;
        end
        if (busy) begin
          bcnt++;
        end else if (bcnt > 0) begin
          if (exp_busy_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_busy: got %0d cycles expected none", bcnt);
          end else begin
            check("busy_len", 64'(bcnt), 64'(exp_busy_q.pop_front()));
          end
          bcnt = 0;
        end
        prev_clk = clk_tx;
        prev_valid = dout_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_key(input logic [4:0] k, output logic pre_active);
    pre_active = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) pre_active = active;
      valid = 1'b1; key_bit = k[i];
    end
    @(negedge clk);
    valid = 1'b0; key_bit = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got busy expected idle within 5000 cycles");
    end
  endtask

  task automatic config_div(input int d);
    @(negedge clk);
    valid = 1'b1; cfg = 1'b1; din = 4'(d); a = 8'($urandom); sel = 4'($urandom);
    @(negedge clk);
    valid = 1'b0; cfg = 1'b0;
    div_m = d;
    @(negedge clk);
    check("cfg_no_command", 64'(busy), 64'd0);
  endtask

  task automatic push_cmd(input int av, input int bv, input int s, input logic w, input int ad);
    if (mode_m == 0) begin
      exp_frame_q.push_back(with_par(ref_frame(av, bv, s)));
      exp_busy_q.push_back(tx_busy_len());
    end else if (w) begin
      mem_m[ad] = ref_frame(av, bv, s);
      exp_busy_q.push_back(2);
    end else begin
      exp_frame_q.push_back(with_par(mem_m[ad]));
      exp_busy_q.push_back(tx_busy_len());
    end
  endtask

  task automatic run_cmd(input int av, input int bv, input int s, input logic w, input int ad);
    @(negedge clk);
    valid = 1'b1; a = 8'(av); b = 8'(bv); sel = 4'(s); rw = w; addr = 2'(ad);
    push_cmd(av, bv, s, w, ad);
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_frame_q.delete();
    exp_busy_q.delete();
    for (int i = 0; i < 4; i++) mem_m[i] = '0;
    div_m = 0; mode_m = 0;
    @(negedge clk);
    check("reset_outputs", 64'({dout_valid, data_out, clk_tx, busy, active, mode, locked}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic pre;
    int av, bv, s, n;
    for (int i = 0; i < 4; i++) mem_m[i] = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({dout_valid, data_out, clk_tx, busy, active, mode, locked}), 64'd0);
    rst_n = 1'b1;

    // Brute-force lockout.
    for (int i = 0; i < 3; i++) begin
      send_key(5'b00111, pre);
      check("wrong_key_status", 64'({active, locked}), 64'({1'b0, i == 2}));
    end
    send_key(5'b00101, pre);
    check("locked_ignores_key", 64'({active, locked}), 64'b01);
    do_reset();
    check("lock_cleared", 64'({active, locked}), 64'b00);

    // Mode 0: unlock, program divider, directed frame then randomised operations.
    send_key(5'b00101, pre);
    check("key_pre_active", 64'(pre), 64'd0);
    check("key_mode0", 64'({active, mode}), 64'b10);
    mode_m = 0;
    config_div(1);
    run_cmd(5, 1, 5, 1'b0, 0);
    run_cmd(8'h81, 9, 6, 1'b0, 0);
    run_cmd(8'h81, 9, 8, 1'b0, 0);
    run_cmd(8'h81, 9, 9, 1'b0, 0);
    run_cmd(8'h81, 9, 7, 1'b0, 0);
    run_cmd(3, 8, 11, 1'b0, 0);
    run_cmd(7, 7, 10, 1'b0, 0);
    run_cmd(8'hFF, 8'hFF, 15, 1'b0, 0);
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) config_div($urandom_range(0, 2));
      run_cmd($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15), 1'b0, 0);
    end

    // ValidCmd held high: inputs changed mid-frame are ignored, then re-issued from IDLE.
    @(negedge clk);
    valid = 1'b1; a = 8'h3C; b = 8'h11; sel = 4'd0;
    push_cmd(8'h3C, 8'h11, 0, 1'b0, 0);
    @(negedge clk);
    repeat (10) @(negedge clk);
    a = 8'hA5; b = 8'h0F; sel = 4'd4;
    push_cmd(8'hA5, 8'h0F, 4, 1'b0, 0);
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    valid = 1'b0;
    wait_idle();

    // Mode 1: stores and reads, including an unwritten address.
    do_reset();
    send_key(5'b10101, pre);
    check("key_mode1", 64'({active, mode}), 64'b11);
    mode_m = 1;
    run_cmd(5, 2, 1, 1'b1, 0);
    run_cmd(3, 8, 3, 1'b1, 1);
    run_cmd(2, 2, 1, 1'b1, 3);
    for (int i = 0; i < 4; i++) run_cmd($urandom_range(0, 255), 0, 0, 1'b0, i);
    config_div(2);
    for (int i = 0; i < 10; i++) begin
      av = $urandom_range(0, 255); bv = $urandom_range(0, 255); s = $urandom_range(0, 15);
      run_cmd(av, bv, s, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Reset mid-frame: link forced low, memory and unlock cleared.
    @(negedge clk);
    valid = 1'b1; rw = 1'b0; addr = 2'd1;
    @(negedge clk);
    valid = 1'b0;
    repeat (30) @(negedge clk);
    check("tx_in_progress", 64'(dout_valid), 64'd1);
    #2;
    do_reset();
    check("post_reset_active", 64'(active), 64'd0);
    send_key(5'b10101, pre);
    mode_m = 1;
    run_cmd(0, 0, 0, 1'b0, 1);

    repeat (5) @(negedge clk);
    check("frames_outstanding", 64'(exp_frame_q.size()), 64'd0);
    check("busy_outstanding", 64'(exp_busy_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_binar_gen.md
# calc_binar_gen

Parametrised successor of the binary calculator: a key-locked ALU with a generic operand width, a result memory of configurable depth, 16 operations, a programmable serial transmitter and a brute-force lockout. It sits between the user key/operand inputs and the serial output link. It unlocks on a serial key, then either:

- transmits each computed frame directly (mode 0), or
- stores frames in memory and transmits them on read (mode 1).

## Interface
- WIDTH, 8: operand and result width, ≥ 4.
- ADDR_W, 2: memory address width; depth is 2**ADDR_W.
- KEY_LEN, 5: serial key length. The MSB selects the mode; the lower KEY_LEN-1 bits are the code.
- KEY_CODE, 4'b0101: expected code, KEY_LEN-1 bits.
- MAX_TRIES, 3: wrong keys tolerated before lockout.
- DIV_W, 4: width of the divider configuration.
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- A, B  in  WIDTH  operands.
- Sel  in  4  operation select.
- InputKey  in  1  serial key bit, LSB first.
- ValidCmd  in  1  qualifies key bits and commands.
- RW  in  1  mode 1 only: 1 = compute and store, 0 = read and transmit.
- Addr  in  ADDR_W  memory address.
- Din  in  DIV_W  divider value.
- ConfigDiv  in  1  load Din into the divider.
- DoutValid, DataOut, ClkTx  out  1  serial link.
- CalcBusy, CalcActive, CalcMode, CalcLocked  out  1  status.

## Operation
- States: KEY, IDLE, CALC, STORE, TX, LOCKED.
- KEY:
  - Each cycle with ValidCmd=1 shifts in one InputKey bit.
  - After KEY_LEN bits, compare bits [KEY_LEN-2:0] with KEY_CODE.
  - Match: go to IDLE, set CalcActive=1 and CalcMode=key MSB.
  - Mismatch: increment the fail counter and restart entry.
  - Fail counter reaching MAX_TRIES: go to LOCKED. CalcLocked=1 until Reset; all inputs are ignored.
- IDLE, when ValidCmd=1:
  - ConfigDiv=1: load DivReg←Din. ConfigDiv has priority over commands and is held the same cycle.
  - Mode 0: capture A, B, Sel and go to CALC, then TX.
  - Mode 1, RW=1: capture and go to CALC, then STORE. STORE writes the frame to mem[Addr] and returns to IDLE.
  - Mode 1, RW=0: load mem[Addr] and go to TX.
- ALU (Sel), result is WIDTH bits:
  - 0 add, 1 sub (mod 2**WIDTH), 2 and, 3 or, 4 xor, 5 ~A.
  - 6 A<<B, 7 A>>B, using shift amount B mod WIDTH.
  - 8 rotl, 9 rotr.
  - 10 A==B and 11 A<B (unsigned): result 1 or 0, zero-extended.
  - 12 low half of A*B, 13 max, 14 min, 15 A+1.
- Frame: {Sel, A, B, Result}, FRAME = 4+3·WIDTH bits, transmitted MSB first.
- TX:
  - ClkTx toggles every DivReg+1 cycles, giving a bit period of 2·(DivReg+1) cycles.
  - DataOut changes on ClkTx falling edges; the receiver samples on rising edges.
  - DoutValid=1 for the whole frame. Return to IDLE after the last bit's high phase.
- A ValidCmd held high re-issues the command from IDLE.
- Inputs changing while CalcBusy=1 are ignored.
- Memory is held in registers cleared by reset. Reading an unwritten entry transmits all zeros.
- Reset outputs: DoutValid=0, DataOut=0, ClkTx=0, CalcBusy=0, CalcActive=0, CalcMode=0, CalcLocked=0.
- Reset also clears DivReg, the fail counter, the key shifter and memory.

## Timing
- A command accepted in IDLE at cycle N gives:
  - CalcBusy=1 from N+1.
  - CALC at N+1.
  - TX at N+2, or the STORE write at N+2 and back to IDLE at N+3.
- A TX frame makes CalcBusy=1 for FRAME·2·(DivReg+1)+1 cycles.
- On the last key bit at cycle K, CalcActive=1 from K+1.
- Reset asserted mid-TX forces outputs low immediately. The key must be re-entered.

## Configuration
- CALC_PARITY_EN defined: an even-parity bit over the frame is appended after the LSB, giving FRAME+1 bits and a proportionally longer TX phase.
- Not defined: no parity bit, FRAME bits only.

## Structure
- calc_pkg holds:
  - the state enum;
  - the Sel opcode enum;
  - a function frame_len(WIDTH).
- One sub-module, calc_tx_serializer, holds the divider, shifter and ClkTx/DataOut/DoutValid generation. Its interface is load/frame/busy.

## Test plan
1. Key 00101 (InputKey bits 1,0,1,0,0) → CalcActive=1 and CalcMode=0 one cycle after the 5th bit. Key 10101 → CalcMode=1.
2. Three wrong keys of 00111 → CalcLocked=1. A subsequent correct key is ignored; Reset clears the lock.
3. Mode 0, Din=1 with ConfigDiv, then A=5, B=1, Sel=5 → frame 0101_00000101_00000001_11111010. Bit period is 4 cycles; CalcBusy lasts 113 cycles.
4. Mode 1:
   - Stores: (5,2,Sel=1)@0, (3,8,Sel=3)@1, (2,2,Sel=1)@3.
   - Reads of 0–3 → results 0x03, 0x0B, 0x00 (unwritten, all-zero frame), 0x00.
5. Reset asserted mid-TX → all outputs 0 next sample. Memory is cleared and CalcActive=0.
6. Sel=6/8 with B=9, WIDTH=8 → shift/rotate by 1. Sel=11 with A=3, B=8 → result 1.
